// File: rtl/processor_control_unit.sv
// Multicycle Moore control unit: fetch/decode/sequence for a 16x16 RF datapath.
// Define CU_JPZ_EN to build the JPZ (jump if Ra==0) instruction, opcode 6.
module processor_control_unit #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [15:0]        imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_rd,
  output logic               dmem_wr,
  output logic               rf_wr_sel,
  output logic [3:0]         rf_w_addr,
  output logic               rf_w_wr,
  output logic [3:0]         rf_ra_addr,
  output logic [3:0]         rf_rb_addr,
  output logic [1:0]         alu_op,
  input  logic               rf_ra_zero,
  output logic               halted,
  output logic               illegal,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
`ifdef CU_JPZ_EN
    S_HALT   = 4'd9,
    S_JPZ    = 4'd10
`else
    S_HALT   = 4'd9
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic              r_halted;
  logic              r_illegal;

  logic [3:0]        w_op;
  logic [3:0]        w_ra;
  logic [3:0]        w_rb;
  logic [3:0]        w_rc;
  logic [7:0]        w_d;
  logic              w_is_nop;
  logic              w_is_ld;
  logic              w_is_st;
  logic              w_is_add;
  logic              w_is_sub;
  logic              w_is_halt;
  logic              w_is_jpz;
  logic              w_is_bad;

  assign w_op = r_ir[15:12];
  assign w_ra = r_ir[11:8];
  assign w_rb = r_ir[7:4];
  assign w_rc = r_ir[3:0];
  assign w_d  = r_ir[7:0];

  assign w_is_nop  = (w_op == 4'd0);
  assign w_is_ld   = (w_op == 4'd1);
  assign w_is_st   = (w_op == 4'd2);
  assign w_is_add  = (w_op == 4'd3);
  assign w_is_sub  = (w_op == 4'd4);
  assign w_is_halt = (w_op == 4'd5);

`ifdef CU_JPZ_EN
  logic [PC_W-1:0] w_off;
  assign w_is_jpz = (w_op == 4'd6);
  assign w_off    = PC_W'($signed(w_d));
`else
  logic w_unused;
  assign w_is_jpz = 1'b0;
  assign w_unused = rf_ra_zero;
`endif

  assign w_is_bad = ~(w_is_nop | w_is_ld | w_is_st | w_is_add |
                      w_is_sub | w_is_halt | w_is_jpz);

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_INIT;
    else         r_state <= w_next;
  end

  // Next-state logic; HALT is absorbing, unknown opcodes end in HALT
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          w_is_nop: w_next = S_NOOP;
          w_is_ld:  w_next = S_LOAD_A;
          w_is_st:  w_next = S_STORE;
          w_is_add: w_next = S_ADD;
          w_is_sub: w_next = S_SUB;
`ifdef CU_JPZ_EN
          w_is_jpz: w_next = S_JPZ;
`endif
          default:  w_next = S_HALT;
        endcase
      end
      S_LOAD_A: w_next = S_LOAD_B;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // PC and IR; JPZ target is relative to the JPZ's own address
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_pc <= '0;
      r_ir <= '0;
    end else if (r_state == S_FETCH) begin
      r_ir <= imem_data;
      r_pc <= r_pc + PC_W'(1);
`ifdef CU_JPZ_EN
    end else if (r_state == S_JPZ && rf_ra_zero) begin
      r_pc <= r_pc + w_off - PC_W'(1);
`endif
    end
  end

  // Sticky halt / illegal flags, latched as DECODE leaves
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == S_DECODE) begin
      if (w_is_halt || w_is_bad) r_halted  <= 1'b1;
      if (w_is_bad)              r_illegal <= 1'b1;
    end
  end

  // Datapath strobes and addresses, purely from state and IR
  always_comb begin
    dmem_addr  = '0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    rf_wr_sel  = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_op     = 2'b00;
    unique case (r_state)
      S_LOAD_A: begin
        dmem_addr = w_d[DADDR_W-1:0];
        dmem_rd   = 1'b1;
      end
      S_LOAD_B: begin
        dmem_addr = w_d[DADDR_W-1:0];
        rf_wr_sel = 1'b1;
        rf_w_addr = w_ra;
        rf_w_wr   = 1'b1;
      end
      S_STORE: begin
        rf_ra_addr = w_ra;
        dmem_addr  = w_d[DADDR_W-1:0];
        dmem_wr    = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = w_rb;
        rf_rb_addr = w_rc;
        alu_op     = (r_state == S_ADD) ? 2'b01 : 2'b10;
        rf_w_addr  = w_ra;
        rf_w_wr    = 1'b1;
      end
`ifdef CU_JPZ_EN
      S_JPZ: rf_ra_addr = w_ra;
`endif
      default: ;
    endcase
  end

  assign imem_addr = r_pc;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_processor_control_unit.sv
// Scoreboard bench for processor_control_unit.
// Expected PCs, fetch spacings and execute-cycle outputs are queued up front.
module tb_processor_control_unit;

  logic        clock;
  logic        resetN;
  logic [15:0] imem_data;
  logic [6:0]  imem_addr;
  logic [7:0]  dmem_addr;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        rf_wr_sel;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [1:0]  alu_op;
  logic        rf_ra_zero;
  logic        halted;
  logic        illegal;
  logic [3:0]  state_dbg;

  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_NOOP = 4'd3;
  localparam logic [3:0] S_LDA = 4'd4;
  localparam logic [3:0] S_LDB = 4'd5;
  localparam logic [3:0] S_ST = 4'd6;
  localparam logic [3:0] S_ADD = 4'd7;
  localparam logic [3:0] S_SUB = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;
  localparam logic [3:0] S_JPZ = 4'd10;

  logic [15:0] imem [128];
  assign imem_data = imem[imem_addr];

  processor_control_unit #(.PC_W(7), .DADDR_W(8)) dut (
    .clock(clock), .resetN(resetN),
    .imem_data(imem_data), .imem_addr(imem_addr),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .rf_wr_sel(rf_wr_sel), .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .alu_op(alu_op), .rf_ra_zero(rf_ra_zero),
    .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk;
  int n_err;
  int cyc;
  int prev_f;
  bit pv;
  logic [29:0] exq[$];
  int pcq[$];
  int latq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] mk(
    input logic [3:0] st, input logic [7:0] da,
    input logic rd, input logic wr, input logic sel,
    input logic [3:0] wa, input logic ww,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [1:0] op);
    return {st, da, rd, wr, sel, wa, ww, ra, rb, op};
  endfunction

  function automatic logic [29:0] obs();
    return {state_dbg, dmem_addr, dmem_rd, dmem_wr, rf_wr_sel,
            rf_w_addr, rf_w_wr, rf_ra_addr, rf_rb_addr, alu_op};
  endfunction

  function automatic logic [29:0] nop_v();
    return mk(S_NOOP, 8'h00, 0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 2'b00);
  endfunction

  // Monitor: checks PC and fetch spacing at FETCH, outputs in execute states
  initial begin
    cyc = 0;
    pv = 0;
    prev_f = 0;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        pv = 0;
      end else if (state_dbg == S_FETCH) begin
        chk("pcq_avail", 32'(pcq.size() > 0), 1);
        if (pcq.size() > 0) chk("pc", 32'(imem_addr), pcq.pop_front());
        if (pv) begin
          chk("latq_avail", 32'(latq.size() > 0), 1);
          if (latq.size() > 0) chk("lat", cyc - prev_f, latq.pop_front());
        end
        prev_f = cyc;
        pv = 1;
      end else if (state_dbg inside {S_NOOP, S_LDA, S_LDB, S_ST,
                                     S_ADD, S_SUB, S_JPZ}) begin
        chk("exq_avail", 32'(exq.size() > 0), 1);
        if (exq.size() > 0) chk("exec", 32'(obs()), 32'(exq.pop_front()));
      end
      cyc++;
    end
  end

  task automatic clr_imem();
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    exq.delete();
    pcq.delete();
    latq.delete();
    clr_imem();
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s,
                            input int lim);
    for (int i = 0; i < lim && state_dbg != s; i++) @(negedge clock);
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  task automatic wait_halt(input string tag, input int lim);
    for (int i = 0; i < lim && halted !== 1'b1; i++) @(negedge clock);
    chk(tag, 32'(halted), 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rf_ra_zero = 1'b0;
    resetN = 1'b0;
    clr_imem();
    repeat (2) @(negedge clock);

    chk("rst_vec", 32'(obs()), 0);
    chk("rst_pc", 32'(imem_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);

    // Straight-line program: LOAD, ADD, SUB, STORE, NOOP, HALT
    imem[0] = 16'h1105;
    imem[1] = 16'h3312;
    imem[2] = 16'h4312;
    imem[3] = 16'h230A;
    imem[4] = 16'h0000;
    imem[5] = 16'h5000;
    for (int i = 0; i < 6; i++) pcq.push_back(i);
    latq = '{4, 3, 3, 3, 3};
    exq.push_back(mk(S_LDA, 8'h05, 1, 0, 0, 4'd0, 0, 4'd0, 4'd0, 2'b00));
    exq.push_back(mk(S_LDB, 8'h05, 0, 0, 1, 4'd1, 1, 4'd0, 4'd0, 2'b00));
    exq.push_back(mk(S_ADD, 8'h00, 0, 0, 0, 4'd3, 1, 4'd1, 4'd2, 2'b01));
    exq.push_back(mk(S_SUB, 8'h00, 0, 0, 0, 4'd3, 1, 4'd1, 4'd2, 2'b10));
    exq.push_back(mk(S_ST, 8'h0A, 0, 1, 0, 4'd0, 0, 4'd3, 4'd0, 2'b00));
    exq.push_back(nop_v());
    resetN = 1'b1;
    wait_halt("a_halted", 60);
    chk("a_illegal", 32'(illegal), 0);
    chk("a_state", 32'(state_dbg), 32'(S_HALT));
    chk("a_exq_left", exq.size(), 0);
    chk("a_pcq_left", pcq.size(), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("a_pc_frozen", 32'(imem_addr), 6);
    end

    // Reset asserted in the middle of the ADD state
    do_reset();
    imem[0] = 16'h3312;
    imem[1] = 16'h5000;
    pcq.push_back(0);
    exq.push_back(mk(S_ADD, 8'h00, 0, 0, 0, 4'd3, 1, 4'd1, 4'd2, 2'b01));
    resetN = 1'b1;
    wait_state("b_reach_add", S_ADD, 10);
    #2 resetN = 1'b0;
    #1;
    chk("b_wr_dropped", 32'(rf_w_wr), 0);
    chk("b_state_init", 32'(state_dbg), 32'(S_INIT));
    chk("b_exq_left", exq.size(), 0);
    pcq.delete();
    latq.delete();
    @(negedge clock);
    @(negedge clock);
    pcq = '{0, 1};
    latq = '{3};
    exq.push_back(mk(S_ADD, 8'h00, 0, 0, 0, 4'd3, 1, 4'd1, 4'd2, 2'b01));
    resetN = 1'b1;
    #1;
    chk("b_pc_after", 32'(imem_addr), 0);
    wait_halt("b_halted", 30);
    chk("b_illegal", 32'(illegal), 0);

    // Undefined opcode: halted and illegal the cycle after DECODE
    do_reset();
    imem[0] = 16'hF000;
    pcq.push_back(0);
    resetN = 1'b1;
    wait_state("c_decode", S_DECODE, 10);
    chk("c_halted_pre", 32'(halted), 0);
    @(negedge clock);
    chk("c_halted", 32'(halted), 1);
    chk("c_illegal", 32'(illegal), 1);
    chk("c_state", 32'(state_dbg), 32'(S_HALT));

    // Opcode 6 at PC 4
`ifdef CU_JPZ_EN
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      imem[4] = 16'h6410;
      imem[5] = 16'h5000;
      imem[7'h14] = 16'h5000;
      rf_ra_zero = z[0];
      for (int i = 0; i < 5; i++) pcq.push_back(i);
      pcq.push_back(z ? 8'h14 : 8'h05);
      latq = '{3, 3, 3, 3, 3};
      for (int i = 0; i < 4; i++) exq.push_back(nop_v());
      exq.push_back(mk(S_JPZ, 8'h00, 0, 0, 0, 4'd0, 0, 4'd4, 4'd0, 2'b00));
      resetN = 1'b1;
      wait_halt("d_halted", 60);
      chk("d_illegal", 32'(illegal), 0);
      chk("d_pc", 32'(imem_addr), z ? 32'h15 : 32'h06);
      chk("d_pcq_left", pcq.size(), 0);
    end
    rf_ra_zero = 1'b0;
`else
    do_reset();
    imem[4] = 16'h6410;
    imem[5] = 16'h5000;
    rf_ra_zero = 1'b1;
    for (int i = 0; i < 5; i++) pcq.push_back(i);
    latq = '{3, 3, 3, 3};
    for (int i = 0; i < 4; i++) exq.push_back(nop_v());
    resetN = 1'b1;
    wait_halt("d_halted", 60);
    chk("d_illegal", 32'(illegal), 1);
    chk("d_pc", 32'(imem_addr), 5);
    rf_ra_zero = 1'b0;
`endif

    // PC wrap: NOOPs through 0x7F back to 0, then HALT at 1
    do_reset();
    for (int i = 0; i < 128; i++) pcq.push_back(i);
    pcq.push_back(0);
    pcq.push_back(1);
    for (int i = 0; i < 129; i++) begin
      latq.push_back(3);
      exq.push_back(nop_v());
    end
    resetN = 1'b1;
    for (int i = 0; i < 20 && imem_addr != 7'd2; i++) @(negedge clock);
    chk("e_pc_two", 32'(imem_addr), 2);
    imem[1] = 16'h5000;
    wait_halt("e_halted", 600);
    chk("e_pc", 32'(imem_addr), 2);
    chk("e_pcq_left", pcq.size(), 0);
    chk("e_exq_left", exq.size(), 0);
    chk("e_illegal", 32'(illegal), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
